// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 64-bit combinational ALU: accepts one op,
// holds operands, times execution, captures and returns the result.
// Ports: clock/reset_n; req_* valid/ready request in; alu_* operands and
// flags out, alu_c/f3/addrch/naddr results in; rsp_* valid/ready out; busy.
module alu_issue_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int BASE_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_instr,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  input  logic [63:0] req_reg8,
  input  logic [31:0] req_value,
  input  logic        req_highlow,
  output logic [5:0]  alu_instr,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [63:0] alu_reg8,
  output logic [31:0] alu_value,
  output logic        alu_highlow,
  output logic        alu_f1,
  output logic        alu_f2,
  input  logic [63:0] alu_c,
  input  logic        alu_f3,
  input  logic        alu_addrch,
  input  logic [63:0] alu_naddr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_branch,
  output logic [63:0] rsp_target,
  output logic        rsp_err,
  output logic        busy
);

  if (MULDIV_CYCLES < 1 || MULDIV_CYCLES > 15) begin : g_bad_md
    $error("MULDIV_CYCLES must be 1..15");
  end
  if (BASE_CYCLES < 1 || BASE_CYCLES > 15) begin : g_bad_base
    $error("BASE_CYCLES must be 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  instr_q, instr_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] reg8_q, reg8_d;
  logic [31:0] value_q, value_d;
  logic        hl_q, hl_d;
  logic        f1_q, f1_d;
  logic        f2_q, f2_d;
  logic [63:0] res_q, res_d;
  logic        br_q, br_d;
  logic [63:0] tgt_q, tgt_d;
  logic        err_q, err_d;

  logic is_md, is_ill, is_cmp, div0;

  assign is_md  = (req_instr == 6'd16)
                | (req_instr == 6'd17);
  assign is_ill = req_instr > 6'd17;
  assign is_cmp = (instr_q >= 6'd8)
                & (instr_q <= 6'd13);
  assign div0   = (instr_q == 6'd17)
                & (b_q == 64'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    a_d     = a_q;
    b_d     = b_q;
    reg8_d  = reg8_q;
    value_d = value_q;
    hl_d    = hl_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    res_d   = res_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          instr_d = req_instr;
          a_d     = req_a;
          b_d     = req_b;
          reg8_d  = req_reg8;
          value_d = req_value;
          hl_d    = req_highlow;
          cnt_d   = is_md ? 4'(MULDIV_CYCLES - 1)
                          : 4'(BASE_CYCLES - 1);
          if (is_ill) begin
            // Illegal ops never reach the ALU result path.
            state_d = RESP;
            res_d   = '0;
            br_d    = 1'b0;
            tgt_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          res_d   = div0 ? '1 : alu_c;
          err_d   = div0;
          br_d    = alu_addrch;
          tgt_d   = alu_addrch ? alu_naddr : '0;
          if (is_cmp) begin
            f2_d = f1_q;
            f1_d = alu_f3;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      reg8_q  <= '0;
      value_q <= '0;
      hl_q    <= 1'b0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      res_q   <= '0;
      br_q    <= 1'b0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      reg8_q  <= reg8_d;
      value_q <= value_d;
      hl_q    <= hl_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      res_q   <= res_d;
      br_q    <= br_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  // Gated by reset_n so the request port is closed during reset.
  assign req_ready   = (state_q == IDLE) & reset_n;
  assign busy        = state_q != IDLE;
  assign rsp_valid   = state_q == RESP;
  assign alu_instr   = instr_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_reg8    = reg8_q;
  assign alu_value   = value_q;
  assign alu_highlow = hl_q;
  assign alu_f1      = f1_q;
  assign alu_f2      = f2_q;
  assign rsp_result  = res_q;
  assign rsp_branch  = br_q;
  assign rsp_target  = tgt_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a tiny behavioural ALU.
// Ops: 0 add, 8 eq, 9 lt, 15 branch-on-F1, 16 mul, 17 div.
module tb_alu_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_instr = '0;
  logic [63:0] req_a = '0;
  logic [63:0] req_b = '0;
  logic [63:0] req_reg8 = '0;
  logic [31:0] req_value = '0;
  logic        req_highlow = 1'b0;
  logic [5:0]  alu_instr;
  logic [63:0] alu_a, alu_b, alu_reg8;
  logic [31:0] alu_value;
  logic        alu_highlow, alu_f1, alu_f2;
  logic [63:0] alu_c;
  logic        alu_f3, alu_addrch;
  logic [63:0] alu_naddr;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_branch;
  logic [63:0] rsp_target;
  logic        rsp_err;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int lat;

  alu_issue_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .req_a(req_a),
    .req_b(req_b), .req_reg8(req_reg8),
    .req_value(req_value),
    .req_highlow(req_highlow),
    .alu_instr(alu_instr), .alu_a(alu_a),
    .alu_b(alu_b), .alu_reg8(alu_reg8),
    .alu_value(alu_value),
    .alu_highlow(alu_highlow),
    .alu_f1(alu_f1), .alu_f2(alu_f2),
    .alu_c(alu_c), .alu_f3(alu_f3),
    .alu_addrch(alu_addrch),
    .alu_naddr(alu_naddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_branch(rsp_branch),
    .rsp_target(rsp_target),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_c      = '0;
    alu_f3     = 1'b0;
    alu_addrch = 1'b0;
    alu_naddr  = alu_reg8;
    case (alu_instr)
      6'd0:  alu_c = alu_a + alu_b;
      6'd8:  alu_f3 = alu_a == alu_b;
      6'd9:  alu_f3 = alu_a < alu_b;
      6'd15: alu_addrch = alu_f1;
      6'd16: alu_c = alu_a * alu_b;
      6'd17: alu_c = (alu_b != 0) ? alu_a / alu_b
                                  : 64'hDEAD;
      default: ;
    endcase
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Issue at a negedge; lat counts the accept edge as edge 1.
  task automatic do_op(input logic [5:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       input logic [63:0] r8,
                       output int l);
    int n;
    @(negedge clock);
    req_instr = op;
    req_a     = a;
    req_b     = b;
    req_reg8  = r8;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 40) begin
      @(posedge clock);
      #1;
      l++;
    end
  endtask

  task automatic release_rsp();
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_f1", 64'(alu_f1), 0);
    chk("rst_result", rsp_result, 0);
    @(negedge clock);
    reset_n = 1'b1;

    do_op(6'd0, 64'd5, 64'd7, 64'd0, lat);
    chk("add_lat", 64'(lat), 2);
    chk("add_res", rsp_result, 12);
    chk("add_err", 64'(rsp_err), 0);
    chk("add_f1", 64'(alu_f1), 0);
    chk("add_f2", 64'(alu_f2), 0);
    release_rsp();
    chk("add_idle", 64'(busy), 0);

    do_op(6'd9, 64'd3, 64'd9, 64'd0, lat);
    chk("cmp1_f1", 64'(alu_f1), 1);
    chk("cmp1_f2", 64'(alu_f2), 0);
    release_rsp();
    do_op(6'd8, 64'd1, 64'd2, 64'd0, lat);
    chk("cmp2_f1", 64'(alu_f1), 0);
    chk("cmp2_f2", 64'(alu_f2), 1);
    release_rsp();

    do_op(6'd9, 64'd3, 64'd9, 64'd0, lat);
    release_rsp();
    do_op(6'd15, 64'd0, 64'd0, 64'h40, lat);
    chk("br1_taken", 64'(rsp_branch), 1);
    chk("br1_tgt", rsp_target, 64'h40);
    release_rsp();
    do_op(6'd8, 64'd1, 64'd2, 64'd0, lat);
    release_rsp();
    do_op(6'd15, 64'd0, 64'd0, 64'h40, lat);
    chk("br0_taken", 64'(rsp_branch), 0);
    chk("br0_tgt", rsp_target, 0);
    release_rsp();

    do_op(6'd17, 64'd100, 64'd7, 64'd0, lat);
    chk("div_lat", 64'(lat), 5);
    chk("div_res", rsp_result, 14);
    chk("div_err", 64'(rsp_err), 0);
    release_rsp();
    do_op(6'd17, 64'd100, 64'd0, 64'd0, lat);
    chk("div0_res", rsp_result, '1);
    chk("div0_err", 64'(rsp_err), 1);
    release_rsp();

    do_op(6'd16, 64'd6, 64'd7, 64'd0, lat);
    chk("mul_lat", 64'(lat), 5);
    chk("mul_res", rsp_result, 42);
    release_rsp();

    // Backpressure with a second request waiting.
    do_op(6'd0, 64'd1, 64'd2, 64'd0, lat);
    req_instr = 6'd0;
    req_a     = 64'd10;
    req_b     = 64'd20;
    req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("bp_res", rsp_result, 3);
      chk("bp_valid", 64'(rsp_valid), 1);
      chk("bp_ready", 64'(req_ready), 0);
      chk("bp_alu_a", alu_a, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    chk("bp_idle", 64'(busy), 0);
    chk("bp_vld0", 64'(rsp_valid), 0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("bp_acc", alu_a, 10);
    chk("bp_busy", 64'(busy), 1);
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bp2_res", rsp_result, 30);
    release_rsp();

    do_op(6'd9, 64'd3, 64'd9, 64'd0, lat);
    release_rsp();
    do_op(6'd40, 64'd1, 64'd1, 64'd0, lat);
    chk("ill_lat", 64'(lat), 1);
    chk("ill_err", 64'(rsp_err), 1);
    chk("ill_res", rsp_result, 0);
    chk("ill_br", 64'(rsp_branch), 0);
    chk("ill_instr", 64'(alu_instr), 40);
    chk("ill_f1", 64'(alu_f1), 1);
    chk("ill_f2", 64'(alu_f2), 0);
    release_rsp();

    // Reset in the middle of a mul.
    @(negedge clock);
    req_instr = 6'd16;
    req_a     = 64'd6;
    req_b     = 64'd7;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("mr_exec", 64'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 64'(busy), 0);
    chk("mr_vld", 64'(rsp_valid), 0);
    chk("mr_f1", 64'(alu_f1), 0);
    chk("mr_f2", 64'(alu_f2), 0);
    chk("mr_ready", 64'(req_ready), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("mr_novld", 64'(rsp_valid), 0);
    chk("mr_rdy", 64'(req_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequences single operations into the 64-bit combinational ALU through a valid/ready request port.
- Registers the ALU operands, waits a fixed latency, then captures result, branch target and comparison flag.
- Returns everything on a valid/ready response port.
- Owns the architectural flag pair F1/F2 that the ALU reads. It sits between instruction decode and the ALU/PC-update logic.

Parameters:
- MULDIV_CYCLES, 4, total EXEC cycles allowed for opcodes 16 (mul) and 17 (div). Legal range 1..15.
- BASE_CYCLES, 1, EXEC cycles for all other legal opcodes. Legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_instr  in  6  ALU opcode (0..17 legal)
- req_a  in  64  operand A
- req_b  in  64  operand B
- req_reg8  in  64  branch target source
- req_value  in  32  load immediate
- req_highlow  in  1  load half select (1 = upper)
- alu_instr  out  6  registered opcode to ALU
- alu_a, alu_b, alu_reg8  out  64 each  registered operands to ALU
- alu_value  out  32  registered immediate
- alu_highlow  out  1  registered half select
- alu_f1, alu_f2  out  1 each  current flag register
- alu_c  in  64  ALU result
- alu_f3  in  1  ALU flag result
- alu_addrch  in  1  ALU branch-taken
- alu_naddr  in  64  ALU branch target
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  captured result
- rsp_branch  out  1  branch taken
- rsp_target  out  64  branch target (0 if not taken)
- rsp_err  out  1  illegal opcode or divide by zero
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, while reset_n = 0):
  - state = IDLE.
  - All alu_* outputs = 0.
  - F1 = F2 = 0.
  - rsp_valid = 0; rsp_result, rsp_target, rsp_branch, rsp_err = 0.
  - busy = 0; req_ready = 0 while reset is asserted.
- States are IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, register all req_* into alu_* and go to EXEC.
  - Load cnt = MULDIV_CYCLES-1 for opcodes 16/17, else BASE_CYCLES-1.
- EXEC:
  - req_ready = 0; alu_* held stable.
  - If cnt != 0, decrement cnt.
  - When cnt == 0, capture into the response registers and go to RESP:
    - rsp_result = alu_c.
    - rsp_branch = alu_addrch.
    - rsp_target = alu_naddr if alu_addrch, else 0.
  - Minimum latency is accept edge → rsp_valid high after 1 + BASE_CYCLES edges (2 at default). Mul/div take 1 + MULDIV_CYCLES edges.
- Flag update happens at capture, only for opcodes 8..13: F2 ← old F1, F1 ← alu_f3. All other opcodes leave F1/F2 unchanged.
- Divide by zero: opcode 17 with alu_b == 0 forces rsp_result = all ones and rsp_err = 1. alu_c is ignored in this case.
- Illegal opcode (req_instr > 17):
  - Accepted normally, skips EXEC, goes directly to RESP on the next edge.
  - rsp_result = 0, rsp_branch = 0, rsp_err = 1.
  - Flags unchanged; alu_instr is still registered.
- RESP:
  - rsp_valid = 1; outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
  - req_ready stays 0 in RESP; there is no overlap, so one operation is in flight at most.
- req_valid while not ready is ignored. The requester must hold the request until it is accepted.
- Reset mid-operation (EXEC or RESP) aborts: state IDLE, flags cleared, response dropped.
- Count is 4 bits wide; parameters outside 1..15 are illegal (elaboration assertion).

Test Plan:
- Add: req opcode 0, A=5, B=7, alu_c model = A+B → rsp_valid on 2nd edge after accept, rsp_result=12, rsp_err=0, flags unchanged.
- Compare chain: opcode 9 with A=3, B=9 (F3=1), then opcode 8 with A=1, B=2 (F3=0) → after first F1=1/F2=0, after second F1=0/F2=1.
- Divide: opcode 17, A=100, B=7 → rsp_valid 5 edges after accept, result 14. Then B=0 → result 0xFFFF_FFFF_FFFF_FFFF, rsp_err=1.
- Branch: opcode 15 with F1=1, reg8=0x40 → rsp_branch=1, rsp_target=0x40. With F1=0 → rsp_branch=0, rsp_target=0.
- Backpressure: hold rsp_ready=0 for 6 cycles → rsp_* stable, req_ready=0, a second req_valid is not accepted. Raise rsp_ready → IDLE next edge, then the second request is accepted.
- Illegal opcode 40 → RESP after 1 edge, rsp_err=1, result 0. Separately, reset_n pulsed low during mul EXEC → immediate IDLE, rsp_valid=0, F1=F2=0.
